ps2_key_display: RTL and testbench

//  Display back-end for the PS/2 keyboard path. Takes the current FIFO scan code and its

---
 rtl/ps2_pkg.sv | 63 ++++++
 rtl/hex7seg.sv | 45 ++++
 rtl/ps2_key_display.sv | 90 +++++++++
 tb/tb_ps2_key_display.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 display definitions: scan-code constants, the blank pattern and
// the set-2 scan code to ASCII translation.
package ps2_pkg;

  localparam logic [7:0] SC_NONE  = 8'h00;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] ASCII_NONE = 8'h00;

  // Active-low pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned NUM_DIGITS = 6;

  // Codes outside the table (including break/extended prefixes) map to ASCII_NONE.
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code);
    logic [7:0] chr;
    case (code)
      8'h1C:   chr = 8'h61; // a
      8'h32:   chr = 8'h62;
      8'h21:   chr = 8'h63;
      8'h23:   chr = 8'h64;
      8'h24:   chr = 8'h65;
      8'h2B:   chr = 8'h66;
      8'h34:   chr = 8'h67;
      8'h33:   chr = 8'h68;
      8'h43:   chr = 8'h69;
      8'h3B:   chr = 8'h6A;
      8'h42:   chr = 8'h6B;
      8'h4B:   chr = 8'h6C;
      8'h3A:   chr = 8'h6D;
      8'h31:   chr = 8'h6E;
      8'h44:   chr = 8'h6F;
      8'h4D:   chr = 8'h70;
      8'h15:   chr = 8'h71;
      8'h2D:   chr = 8'h72;
      8'h1B:   chr = 8'h73;
      8'h2C:   chr = 8'h74;
      8'h3C:   chr = 8'h75;
      8'h2A:   chr = 8'h76;
      8'h1D:   chr = 8'h77;
      8'h22:   chr = 8'h78;
      8'h35:   chr = 8'h79;
      8'h1A:   chr = 8'h7A; // z
      8'h45:   chr = 8'h30; // 0
      8'h16:   chr = 8'h31;
      8'h1E:   chr = 8'h32;
      8'h26:   chr = 8'h33;
      8'h25:   chr = 8'h34;
      8'h2E:   chr = 8'h35;
      8'h36:   chr = 8'h36;
      8'h3D:   chr = 8'h37;
      8'h3E:   chr = 8'h38;
      8'h46:   chr = 8'h39; // 9
      8'h29:   chr = 8'h20; // space
      8'h5A:   chr = 8'h0D; // enter
      default: chr = ASCII_NONE;
    endcase
    return chr;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to 7-segment pattern (seg[0]=a .. seg[6]=g), with forced blanking
// and selectable output polarity.
module hex7seg
  import ps2_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] pat_s;

  // Active-low glyph lookup; blank overrides the nibble.
  always_comb begin
    pat_s = SEG_BLANK;
    if (blank_i) begin
      pat_s = SEG_BLANK;
    end else begin
      case (nib_i)
        4'h0:    pat_s = 7'h40;
        4'h1:    pat_s = 7'h79;
        4'h2:    pat_s = 7'h24;
        4'h3:    pat_s = 7'h30;
        4'h4:    pat_s = 7'h19;
        4'h5:    pat_s = 7'h12;
        4'h6:    pat_s = 7'h02;
        4'h7:    pat_s = 7'h78;
        4'h8:    pat_s = 7'h00;
        4'h9:    pat_s = 7'h10;
        4'hA:    pat_s = 7'h08;
        4'hB:    pat_s = 7'h03;
        4'hC:    pat_s = 7'h46;
        4'hD:    pat_s = 7'h21;
        4'hE:    pat_s = 7'h06;
        4'hF:    pat_s = 7'h0E;
        default: pat_s = SEG_BLANK;
      endcase
    end
  end

  assign seg_o = SEG_ACTIVE_LOW ? pat_s : ~pat_s;

endmodule

// File: rtl/ps2_key_display.sv
// Registered display back-end: scan code -> ASCII, and data/ASCII/count bytes
// onto six hex digits, all updated together one clock after the inputs.
module ps2_key_display
  import ps2_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic [7:0] counts,
  output logic [7:0] ascii,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5
);

  localparam logic [6:0] BLANK_PAT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic [7:0] ascii_d;
  logic [7:0] ascii_q;
  logic       data_vld_s;
  logic       blank_data_s;
  logic       blank_ascii_s;
  logic [3:0] nib_s   [NUM_DIGITS];
  logic       blank_s [NUM_DIGITS];
  logic [6:0] seg_d   [NUM_DIGITS];
  logic [6:0] seg_q   [NUM_DIGITS];

  // Translation and blanking decisions for the value being sampled this edge.
  always_comb begin
    ascii_d       = ps2_to_ascii(data);
    data_vld_s    = (data != SC_NONE) && (data != SC_BREAK);
    blank_data_s  = !data_vld_s;
    blank_ascii_s = !data_vld_s || (ascii_d == ASCII_NONE);
  end

  // Digit order: data lo/hi, ascii lo/hi, counts lo/hi; counts never blank.
  always_comb begin
    nib_s[0]   = data[3:0];
    nib_s[1]   = data[7:4];
    nib_s[2]   = ascii_d[3:0];
    nib_s[3]   = ascii_d[7:4];
    nib_s[4]   = counts[3:0];
    nib_s[5]   = counts[7:4];
    blank_s[0] = blank_data_s;
    blank_s[1] = blank_data_s;
    blank_s[2] = blank_ascii_s;
    blank_s[3] = blank_ascii_s;
    blank_s[4] = 1'b0;
    blank_s[5] = 1'b0;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex7seg #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_hex7seg (
      .nib_i  (nib_s[g]),
      .blank_i(blank_s[g]),
      .seg_o  (seg_d[g])
    );
  end

  // Output registers; reset blanks every digit and clears the ASCII byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_q <= ASCII_NONE;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_q[i] <= BLANK_PAT;
      end
    end else begin
      ascii_q <= ascii_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_q[i] <= seg_d[i];
      end
    end
  end

  assign ascii = ascii_q;
  assign seg0  = seg_q[0];
  assign seg1  = seg_q[1];
  assign seg2  = seg_q[2];
  assign seg3  = seg_q[3];
  assign seg4  = seg_q[4];
  assign seg5  = seg_q[5];

endmodule

// File: tb/tb_ps2_key_display.sv
// Scoreboard bench for ps2_key_display: expected outputs are queued as each input
// is driven and compared one edge later.
module tb_ps2_key_display;

  typedef struct packed {
    logic [7:0]      ascii;
    logic [5:0][6:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [7:0] counts;
  logic [7:0] ascii;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] ref_ascii [256];
  logic [6:0] ref_glyph [16];

  ps2_key_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .data(data), .counts(counts), .ascii(ascii),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic r, input logic [7:0] d, input logic [7:0] c);
    exp_t       e;
    logic [7:0] a;
    logic       bd, ba;
    if (r) begin
      e.ascii = 8'h00;
      for (int i = 0; i < 6; i++) e.seg[i] = 7'h7F;
    end else begin
      a  = ref_ascii[d];
      bd = (d == 8'h00) || (d == 8'hF0);
      ba = bd || (a == 8'h00);
      e.ascii  = a;
      e.seg[0] = bd ? 7'h7F : ref_glyph[d[3:0]];
      e.seg[1] = bd ? 7'h7F : ref_glyph[d[7:4]];
      e.seg[2] = ba ? 7'h7F : ref_glyph[a[3:0]];
      e.seg[3] = ba ? 7'h7F : ref_glyph[a[7:4]];
      e.seg[4] = ref_glyph[c[3:0]];
      e.seg[5] = ref_glyph[c[7:4]];
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [7:0] d, input logic [7:0] c);
    @(negedge clk);
    rst    = r;
    data   = d;
    counts = c;
    exp_q.push_back(model(r, d, c));
  endtask

  // Compare registered outputs just after each edge against the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ascii", {24'h0, ascii}, {24'h0, e.ascii});
      chk("seg0", {25'h0, seg0}, {25'h0, e.seg[0]});
      chk("seg1", {25'h0, seg1}, {25'h0, e.seg[1]});
      chk("seg2", {25'h0, seg2}, {25'h0, e.seg[2]});
      chk("seg3", {25'h0, seg3}, {25'h0, e.seg[3]});
      chk("seg4", {25'h0, seg4}, {25'h0, e.seg[4]});
      chk("seg5", {25'h0, seg5}, {25'h0, e.seg[5]});
      chk("no_x", {31'h0, $isunknown({ascii, seg0, seg1, seg2, seg3, seg4, seg5})}, 32'h0);
    end
  end

  initial begin
    logic [7:0] letters [26];
    logic [7:0] digits  [10];
    logic [6:0] glyphs  [16];
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    glyphs  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 256; i++) ref_ascii[i] = 8'h00;
    for (int i = 0; i < 26; i++) ref_ascii[letters[i]] = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) ref_ascii[digits[i]] = 8'h30 + 8'(i);
    ref_ascii[8'h29] = 8'h20;
    ref_ascii[8'h5A] = 8'h0D;
    for (int i = 0; i < 16; i++) ref_glyph[i] = glyphs[i];

    rst = 1'b1; data = 8'h1C; counts = 8'h00;
    drive(1'b1, 8'h1C, 8'h00);
    drive(1'b1, 8'h1C, 8'h00);
    drive(1'b0, 8'h1C, 8'h00);   // 'a'
    drive(1'b0, 8'h45, 8'h12);   // '0'
    drive(1'b0, 8'hF0, 8'h00);   // break prefix
    drive(1'b0, 8'h76, 8'h05);   // unmapped
    drive(1'b0, 8'h1C, 8'h01);   // back-to-back
    drive(1'b0, 8'h32, 8'h02);
    drive(1'b0, 8'h21, 8'h03);
    drive(1'b0, 8'h1C, 8'h04);
    drive(1'b1, 8'h32, 8'h05);   // reset mid-sequence
    drive(1'b0, 8'h21, 8'hFF);
    drive(1'b0, 8'hE0, 8'hA7);
    drive(1'b0, 8'h00, 8'h3C);
    drive(1'b0, 8'h29, 8'h80);
    drive(1'b0, 8'h5A, 8'h9E);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 8'(i), 8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
